// File: rtl/sopc_sysid_regs.sv
// System-ID / housekeeping Avalon-MM slave: ID and timestamp words, 64-bit uptime
// counter with atomic LO/HI snapshot, control register, lockable byte-writable scratch.
module sopc_sysid_regs #(
  parameter logic [31:0] SYS_ID        = 32'h5A30268C,
  parameter logic [31:0] TIMESTAMP     = 32'h0,
  parameter int          NUM_SCRATCH   = 4,
  parameter int          READ_LATENCY  = 1,
  // Value the uptime counter takes in reset; left at zero outside wrap-corner simulation.
  parameter logic [63:0] UPTIME_PRESET = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [3:0] ADDR_ID        = 4'd0;
  localparam logic [3:0] ADDR_TIMESTAMP = 4'd1;
  localparam logic [3:0] ADDR_UP_LO     = 4'd2;
  localparam logic [3:0] ADDR_UP_HI     = 4'd3;
  localparam logic [3:0] ADDR_CONTROL   = 4'd4;

  logic [63:0] counter_reg;
  logic [31:0] shadow_reg;
  logic        en_reg;
  logic        lock_reg;
  logic [31:0] scratch_word [8];
  logic [31:0] rd_data_next;

  logic ctrl_wr;
  logic clr_pulse;

  assign ctrl_wr   = write && (address == ADDR_CONTROL);
  assign clr_pulse = ctrl_wr && byteenable[0] && writedata[1];

  // CLR wins over increment; EN updates take effect from the following edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter_reg <= UPTIME_PRESET;
    end else if (clr_pulse) begin
      counter_reg <= 64'h0;
    end else if (en_reg) begin
      counter_reg <= counter_reg + 64'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_reg   <= 1'b1;
      lock_reg <= 1'b0;
    end else begin
      if (ctrl_wr && byteenable[0]) en_reg <= writedata[0];
      if (ctrl_wr && byteenable[1] && writedata[8]) lock_reg <= 1'b1;
    end
  end

  // High half is captured from the same sample that the LO read returns.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_reg <= 32'h0;
    end else if (read && (address == ADDR_UP_LO)) begin
      shadow_reg <= counter_reg[63:32];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_scratch
      if (gi < NUM_SCRATCH) begin : g_used
        logic [31:0] scratch_reg;
        logic        scratch_we;

        assign scratch_we = write && !lock_reg && (address == {1'b1, 3'(gi)});

        always_ff @(posedge clock) begin
          if (reset) begin
            scratch_reg <= 32'h0;
          end else if (scratch_we) begin
            for (int b = 0; b < 4; b++) begin
              if (byteenable[b]) scratch_reg[8*b +: 8] <= writedata[8*b +: 8];
            end
          end
        end

        assign scratch_word[gi] = scratch_reg;
      end else begin : g_unused
        assign scratch_word[gi] = 32'h0;
      end
    end
  endgenerate

  always_comb begin
    rd_data_next = 32'h0;
    if (address[3]) begin
      rd_data_next = scratch_word[address[2:0]];
    end else begin
      case (address)
        ADDR_ID:        rd_data_next = SYS_ID;
        ADDR_TIMESTAMP: rd_data_next = TIMESTAMP;
        ADDR_UP_LO:     rd_data_next = counter_reg[31:0];
        ADDR_UP_HI:     rd_data_next = shadow_reg;
        ADDR_CONTROL:   rd_data_next = {23'h0, lock_reg, 7'h0, en_reg};
        default:        rd_data_next = 32'h0;
      endcase
    end
  end

  // Data stages only advance behind a valid, so readdata holds between pulses.
  logic [31:0]             pipe_data_reg [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_valid_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid_reg <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data_reg[i] <= 32'h0;
    end else begin
      pipe_valid_reg[0] <= read;
      if (read) pipe_data_reg[0] <= rd_data_next;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        if (pipe_valid_reg[i-1]) pipe_data_reg[i] <= pipe_data_reg[i-1];
      end
    end
  end

  assign readdata      = pipe_data_reg[READ_LATENCY-1];
  assign readdatavalid = pipe_valid_reg[READ_LATENCY-1];

endmodule

// File: tb/tb_sopc_sysid_regs.sv
// Bench for sopc_sysid_regs: three instances (latency 1 / 3 / 1, different uptime presets)
// driven one at a time; expected read data and arrival cycle are queued and popped on readdatavalid.
module tb_sopc_sysid_regs;

  localparam logic [31:0] SYS_ID = 32'h5A30268C;
  localparam logic [31:0] TS0    = 32'h20240517;
  localparam logic [31:0] TS1    = 32'hCAFE0001;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  typedef struct {
    int          dut;
    logic [31:0] exp;
    int          due;
    string       nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s   [3];
  logic [3:0]  addr_s  [3];
  logic        read_s  [3];
  logic        write_s [3];
  logic [31:0] wdata_s [3];
  logic [3:0]  be_s    [3];
  logic [31:0] rdata_s [3];
  logic        rdv_s   [3];

  int   lat [3] = '{1, 3, 1};
  int   pulses [3] = '{0, 0, 0};
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q [$];
  vec_t tbl [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sopc_sysid_regs #(.TIMESTAMP(TS0), .READ_LATENCY(1)) dut0 (
    .clock(clk), .reset(rst_s[0]), .address(addr_s[0]), .read(read_s[0]), .write(write_s[0]),
    .writedata(wdata_s[0]), .byteenable(be_s[0]), .readdata(rdata_s[0]), .readdatavalid(rdv_s[0]));

  sopc_sysid_regs #(.TIMESTAMP(TS1), .READ_LATENCY(3), .UPTIME_PRESET(64'h0000_0000_FFFF_FFFD)) dut1 (
    .clock(clk), .reset(rst_s[1]), .address(addr_s[1]), .read(read_s[1]), .write(write_s[1]),
    .writedata(wdata_s[1]), .byteenable(be_s[1]), .readdata(rdata_s[1]), .readdatavalid(rdv_s[1]));

  sopc_sysid_regs #(.READ_LATENCY(1), .UPTIME_PRESET(64'hFFFF_FFFF_FFFF_FFFE)) dut2 (
    .clock(clk), .reset(rst_s[2]), .address(addr_s[2]), .read(read_s[2]), .write(write_s[2]),
    .writedata(wdata_s[2]), .byteenable(be_s[2]), .readdata(rdata_s[2]), .readdatavalid(rdv_s[2]));

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  // Every task starts and ends at a negedge; inputs set here are taken by the next posedge.
  task automatic op(int k, bit wr, bit rd, logic [3:0] a, logic [31:0] wd, logic [3:0] be,
                    logic [31:0] e, string nm);
    exp_t t;
    write_s[k] = wr;
    read_s[k]  = rd;
    addr_s[k]  = a;
    wdata_s[k] = wd;
    be_s[k]    = be;
    if (rd && nm != "") begin
      t.dut = k; t.exp = e; t.due = cyc + lat[k]; t.nm = nm;
      q.push_back(t);
    end
    @(negedge clk);
    write_s[k] = 1'b0;
    read_s[k]  = 1'b0;
  endtask

  task automatic rd(int k, logic [3:0] a, logic [31:0] e, string nm);
    op(k, 1'b0, 1'b1, a, 32'h0, 4'h0, e, nm);
  endtask

  task automatic wr(int k, logic [3:0] a, logic [31:0] wd, logic [3:0] be);
    op(k, 1'b1, 1'b0, a, wd, be, 32'h0, "");
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(int k);
    rst_s[k] = 1'b1;
    repeat (2) @(negedge clk);
    check($sformatf("rst_valid_dut%0d", k), {31'h0, rdv_s[k]}, 32'h0);
    check($sformatf("rst_data_dut%0d", k), rdata_s[k], 32'h0);
    rst_s[k] = 1'b0;
  endtask

  function automatic void add(bit w, bit r, logic [3:0] a, logic [31:0] wd, logic [3:0] be,
                              logic [31:0] e, string nm);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = a; v.wd = wd; v.be = be; v.exp = e; v.nm = nm;
    tbl.push_back(v);
  endfunction

  always @(negedge clk) begin
    exp_t t;
    for (int k = 0; k < 3; k++) begin
      if (rdv_s[k] === 1'b1) begin
        pulses[k]++;
        if (q.size() == 0 || q[0].dut != k) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid dut%0d: got pulse with data %h, required no pulse", k, rdata_s[k]);
        end else begin
          t = q.pop_front();
          $display("dut%0d read %-16s data=%h expected=%h cycle=%0d", k, t.nm, rdata_s[k], t.exp, cyc);
          check(t.nm, rdata_s[k], t.exp);
          check({t.nm, "_latency"}, cyc, t.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p_before;
    int wait_cnt;
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1; addr_s[k] = 4'h0; read_s[k] = 1'b0; write_s[k] = 1'b0;
      wdata_s[k] = 32'h0; be_s[k] = 4'h0;
    end
    @(negedge clk);

    // dut0: counter sample right after reset, then the vector table
    do_reset(0);
    rd(0, 4'd2, 32'd0, "uptime_first");
    rd(0, 4'd2, 32'd1, "uptime_second");
    rd(0, 4'd3, 32'd0, "uptime_hi_first");

    add(0, 1, 4'd0,  32'h0,        4'h0,    SYS_ID,       "id");
    add(0, 1, 4'd1,  32'h0,        4'h0,    TS0,          "timestamp");
    add(0, 1, 4'd0,  32'h0,        4'h0,    SYS_ID,       "pipe_id");
    add(0, 1, 4'd1,  32'h0,        4'h0,    TS0,          "pipe_ts");
    add(0, 1, 4'd15, 32'h0,        4'h0,    32'h0,        "pipe_unmapped");
    add(0, 1, 4'd8,  32'h0,        4'h0,    32'h0,        "pipe_scratch0");
    add(1, 0, 4'd12, 32'hFFFFFFFF, 4'hF,    32'h0,        "");
    add(0, 1, 4'd12, 32'h0,        4'h0,    32'h0,        "unmapped_12");
    add(1, 0, 4'd11, 32'hDEADBEEF, 4'hF,    32'h0,        "");
    add(0, 1, 4'd11, 32'h0,        4'h0,    32'hDEADBEEF, "scratch_top");
    add(1, 0, 4'd8,  32'hA5A5A5A5, 4'b0101, 32'h0,        "");
    add(0, 1, 4'd8,  32'h0,        4'h0,    32'h00A500A5, "scratch_bytes");
    add(1, 1, 4'd9,  32'h00001234, 4'hF,    32'h0,        "rw_same_cycle");
    add(0, 1, 4'd9,  32'h0,        4'h0,    32'h00001234, "rw_next_read");
    add(1, 0, 4'd1,  32'hFFFFFFFF, 4'hF,    32'h0,        "");
    add(0, 1, 4'd1,  32'h0,        4'h0,    TS0,          "ro_timestamp");
    add(1, 0, 4'd4,  32'h00000100, 4'b0010, 32'h0,        "");
    add(1, 0, 4'd8,  32'hFFFFFFFF, 4'hF,    32'h0,        "");
    add(0, 1, 4'd8,  32'h0,        4'h0,    32'h00A500A5, "locked_scratch");
    add(0, 1, 4'd4,  32'h0,        4'h0,    32'h00000101, "control_locked");
    add(1, 0, 4'd4,  32'h00000001, 4'b0011, 32'h0,        "");
    add(0, 1, 4'd4,  32'h0,        4'h0,    32'h00000101, "lock_sticky");
    add(1, 0, 4'd9,  32'hFFFFFFFF, 4'hF,    32'h0,        "");
    add(0, 1, 4'd9,  32'h0,        4'h0,    32'h00001234, "locked_scratch9");
    for (int i = 0; i < tbl.size(); i++)
      op(0, tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wd, tbl[i].be, tbl[i].exp, tbl[i].nm);

    // dut0: counter clear/freeze/resume
    wr(0, 4'd4, 32'h2, 4'h1);
    rd(0, 4'd2, 32'h0, "clr_lo");
    idle(20);
    rd(0, 4'd2, 32'h0, "frozen_lo");
    rd(0, 4'd3, 32'h0, "frozen_hi");
    rd(0, 4'd4, 32'h00000100, "control_frozen");
    wr(0, 4'd4, 32'h1, 4'h1);
    idle(4);
    rd(0, 4'd2, 32'd4, "resumed_lo");

    // dut0: reset clears lock and scratch
    do_reset(0);
    rd(0, 4'd4, 32'h1, "control_after_rst");
    rd(0, 4'd8, 32'h0, "scratch8_after_rst");
    rd(0, 4'd9, 32'h0, "scratch9_after_rst");
    rd(0, 4'd11, 32'h0, "scratch11_after_rst");
    idle(3);

    // dut1: ID at latency 3, then reset while a read is in flight
    do_reset(1);
    rd(1, 4'd0, SYS_ID, "id_lat3");
    rd(1, 4'd1, TS1, "timestamp_lat3");
    idle(4);
    p_before = pulses[1];
    rd(1, 4'd0, 32'h0, "");
    do_reset(1);
    idle(5);
    check("midread_reset_pulses", pulses[1] - p_before, 32'd0);

    // dut1: LO/HI snapshot across the 32-bit carry (counter frozen at 0x0_FFFFFFFE)
    do_reset(1);
    wr(1, 4'd4, 32'h0, 4'h1);
    rd(1, 4'd2, 32'hFFFFFFFE, "atomic_lo");
    idle(2);
    rd(1, 4'd3, 32'h0, "atomic_hi");
    wr(1, 4'd4, 32'h1, 4'h1);
    idle(3);
    rd(1, 4'd2, 32'h1, "carry_lo");
    rd(1, 4'd3, 32'h1, "carry_hi");
    idle(4);

    // dut2: 64-bit wrap from all-ones
    do_reset(2);
    wr(2, 4'd4, 32'h0, 4'h1);
    rd(2, 4'd2, 32'hFFFFFFFF, "ones_lo");
    rd(2, 4'd3, 32'hFFFFFFFF, "ones_hi");
    wr(2, 4'd4, 32'h1, 4'h1);
    wr(2, 4'd4, 32'h0, 4'h1);
    rd(2, 4'd2, 32'h0, "wrap_lo");
    rd(2, 4'd3, 32'h0, "wrap_hi");

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("queue_drained", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
